store_size_rmw: RTL and testbench
=================================

STORE_SIZE_RMW -- requirements
Module: store_size_rmw

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, memory read latency in cycles (legal 1..4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port start  input  1  request to perform one store; sampled only in IDLE.
REQ-005 SHALL have port SScontrol  input  2  store size: 01 sw, 11 sh, 10 sb, 00 no-op.
REQ-006 SHALL have port addr  input  32  byte address of store target.
REQ-007 SHALL have port B_in  input  32  store data from register B.
REQ-008 SHALL have port mem_rdata  input  32  memory read data, valid MEM_LATENCY cycles after address issue.
REQ-009 SHALL have port mem_addr  output  32  memory address.
REQ-010 SHALL have port mem_wdata  output  32  memory write data.
REQ-011 SHALL have port mem_wr  output  1  memory write enable; 0 = read.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE.
REQ-015 SHALL, in IDLE with start=1, latch SScontrol, addr, B_in into internal registers at that edge; later input changes SHALL have no effect on the operation.
REQ-016 SHALL transition from IDLE on start: sw -> WRITE; sh/sb -> READ; 00 -> DONE (no memory write).
REQ-017 SHALL, in READ, drive mem_addr = latched addr and mem_wr=0 for one cycle, then go to WAIT.
REQ-018 SHALL stay in WAIT for MEM_LATENCY cycles via a down-counter loaded on entry; mem_addr held, mem_wr=0.
REQ-019 SHALL, on the last WAIT cycle, capture mem_rdata into a merge register and go to WRITE.
REQ-020 SHALL form write data: sw -> B_in; sh -> {merge[31:16], B_in[15:0]}; sb -> {merge[31:8], B_in[7:0]}.
REQ-021 SHALL, in WRITE, assert mem_wr=1 for exactly one cycle with mem_addr = latched addr and mem_wdata per REQ-020, then go to DONE.
REQ-022 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-023 SHALL ignore start in any state other than IDLE; a start held high after DONE SHALL begin a new operation from IDLE.
REQ-024 SHALL give latency (start edge to done cycle): sw 2 cycles; sh/sb 3+MEM_LATENCY cycles; no-op 1 cycle.
REQ-025 SHALL hold mem_wr=0 in IDLE, READ, WAIT and DONE; mem_wr SHALL never assert for a no-op.
REQ-026 SHALL keep mem_addr and mem_wdata at their last values in IDLE (no spurious changes).

Reset
REQ-027 SHALL, while reset=0, force state IDLE and mem_wr=0, done=0, busy=0, mem_addr=0, mem_wdata=0, all internal registers 0, without waiting for clk.
REQ-028 SHALL, on reset mid-operation (any state), abandon the operation without issuing mem_wr; the first start after release starts a fresh operation.

Verification
REQ-029 SHALL verify sw: addr=0x40, B_in=0xDEADBEEF, start -> mem_wr=1 one cycle after start with mem_wdata=0xDEADBEEF, done next cycle.
REQ-030 SHALL verify sb, MEM_LATENCY=1: mem_rdata=0x11223344, B_in=0x000000AA -> READ, one WAIT, WRITE with mem_wdata=0x112233AA, done at start+4.
REQ-031 SHALL verify sh, MEM_LATENCY=3: mem_rdata=0xCAFE0000, B_in=0x1234BEEF -> mem_wdata=0xCAFEBEEF, mem_wr single cycle, done at start+6.
REQ-032 SHALL verify start pulsed during WAIT and B_in changed mid-op -> ignored; write data uses latched B_in.
REQ-033 SHALL verify reset=0 asserted in WAIT of an sb -> outputs zero immediately, no mem_wr ever; next sw completes normally.
REQ-034 SHALL verify SScontrol=00 with start -> done at start+1, mem_wr stays 0.

Source files
------------

// File: rtl/store_size_rmw.sv
// Sized store unit: sw writes straight through, sh/sb read the target word,
// merge the new low half/byte into it, and write the whole word back.
module store_size_rmw #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  SScontrol,
    input  logic [31:0] addr,
    input  logic [31:0] B_in,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] SS_NOP    = 2'b00;
    localparam logic [1:0] SS_SW     = 2'b01;
    localparam logic [1:0] SS_SB     = 2'b10;
    localparam logic [1:0] SS_SH     = 2'b11;
    localparam logic [1:0] WAIT_LOAD = 2'(MEM_LATENCY - 1);

    state_t      state_q, state_d;
    logic [1:0]  ss_q, ss_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_wr_q, mem_wr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [31:0] merge_store(input logic [1:0]  ss,
                                                input logic [31:0] old_w,
                                                input logic [31:0] b);
        logic [31:0] w;
        case (ss)
            SS_SH:   w = {old_w[31:16], b[15:0]};
            SS_SB:   w = {old_w[31:8], b[7:0]};
            default: w = b;
        endcase
        return w;
    endfunction

    // State, latched operands and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ss_q        <= 2'b00;
            cnt_q       <= 2'b00;
            addr_q      <= 32'h0000_0000;
            data_q      <= 32'h0000_0000;
            merge_q     <= 32'h0000_0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_q        <= ss_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            merge_q     <= merge_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wr_q    <= mem_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; operands are captured only when accepting a request.
    always_comb begin
        state_d = state_q;
        ss_d    = ss_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        merge_d = merge_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ss_d   = SScontrol;
                    addr_d = addr;
                    data_d = B_in;
                    case (SScontrol)
                        SS_SW:        state_d = S_WRITE;
                        SS_SH, SS_SB: state_d = S_READ;
                        SS_NOP:       state_d = S_DONE;
                        default:      state_d = S_DONE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    merge_d = mem_rdata;
                    state_d = S_WRITE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wr_d    = (state_d == S_WRITE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        case (state_d)
            S_READ, S_WAIT: mem_addr_d = addr_d;
            S_WRITE: begin
                mem_addr_d  = addr_d;
                mem_wdata_d = merge_store(ss_d, merge_d, data_d);
            end
            default: mem_addr_d = mem_addr_q;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_store_size_rmw.sv
// Bench for store_size_rmw: two instances (read latency 1 and 3) compared every
// cycle against a timeline model built from per-operation latency and masking rules.
module tb_store_size_rmw;

    localparam int          ML0 = 1;
    localparam int          ML1 = 3;
    localparam logic [31:0] K   = 32'h9E37_79B1;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start_s [2];
    logic [1:0]  ss_s    [2];
    logic [31:0] addr_s  [2];
    logic [31:0] b_s     [2];
    logic [31:0] rdata_s [2];
    logic [31:0] maddr_s [2];
    logic [31:0] wdata_s [2];
    logic        mwr_s   [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [31:0] seed    [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one operation per instance, tracked by cycle offset.
    bit          m_act  [2];
    int          m_off  [2];
    logic [1:0]  m_ss   [2];
    logic [31:0] m_a    [2];
    logic [31:0] m_b    [2];
    logic [31:0] m_rd   [2];
    logic [31:0] e_addr [2];
    logic [31:0] e_wdata[2];

    always #5 clk = ~clk;

    store_size_rmw #(.MEM_LATENCY(ML0)) dut0 (
        .clk(clk), .reset(reset), .start(start_s[0]), .SScontrol(ss_s[0]),
        .addr(addr_s[0]), .B_in(b_s[0]), .mem_rdata(rdata_s[0]),
        .mem_addr(maddr_s[0]), .mem_wdata(wdata_s[0]), .mem_wr(mwr_s[0]),
        .busy(busy_s[0]), .done(done_s[0]));

    store_size_rmw #(.MEM_LATENCY(ML1)) dut1 (
        .clk(clk), .reset(reset), .start(start_s[1]), .SScontrol(ss_s[1]),
        .addr(addr_s[1]), .B_in(b_s[1]), .mem_rdata(rdata_s[1]),
        .mem_addr(maddr_s[1]), .mem_wdata(wdata_s[1]), .mem_wr(mwr_s[1]),
        .busy(busy_s[1]), .done(done_s[1]));

    function automatic logic [31:0] mem_word(input int i, input logic [31:0] a);
        return (a * K) ^ seed[i];
    endfunction

    // Memory with read latency: junk unless an access was in progress that many cycles ago.
    logic [31:0] pipe0;
    logic [31:0] pipe1 [3];
    always @(posedge clk) begin
        pipe0    <= busy_s[0] ? mem_word(0, maddr_s[0]) : 32'hBAD0_0000;
        pipe1[0] <= busy_s[1] ? mem_word(1, maddr_s[1]) : 32'hBAD1_0000;
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rdata_s[0] = pipe0;
    assign rdata_s[1] = pipe1[2];

    function automatic int lat(input int i, input logic [1:0] ss);
        int ml;
        ml = (i == 0) ? ML0 : ML1;
        case (ss)
            2'b01:   return 2;
            2'b00:   return 1;
            default: return 3 + ml;
        endcase
    endfunction

    function automatic logic [31:0] expect_word(input logic [1:0] ss, input logic [31:0] rd,
                                                input logic [31:0] b);
        case (ss)
            2'b11:   return (rd & 32'hFFFF_0000) | (b & 32'h0000_FFFF);
            2'b10:   return (rd & 32'hFFFF_FF00) | (b & 32'h0000_00FF);
            default: return b;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input int i);
        int l;
        if (!reset) begin
            m_act[i]   = 1'b0;
            m_off[i]   = 0;
            e_addr[i]  = 32'h0;
            e_wdata[i] = 32'h0;
        end else if (!m_act[i]) begin
            if (start_s[i]) begin
                m_act[i] = 1'b1;
                m_off[i] = 1;
                m_ss[i]  = ss_s[i];
                m_a[i]   = addr_s[i];
                m_b[i]   = b_s[i];
                m_rd[i]  = mem_word(i, addr_s[i]);
            end
        end else begin
            m_off[i]++;
            if (m_off[i] > lat(i, m_ss[i])) m_act[i] = 1'b0;
        end
        l = lat(i, m_ss[i]);
        if (m_act[i] && m_ss[i] != 2'b00) e_addr[i] = m_a[i];
        if (m_act[i] && m_ss[i] != 2'b00 && m_off[i] == l - 1)
            e_wdata[i] = expect_word(m_ss[i], m_rd[i], m_b[i]);
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int l;
            l = lat(i, m_ss[i]);
            check_eq($sformatf("d%0d_busy", i), 32'(busy_s[i]), 32'(m_act[i]));
            check_eq($sformatf("d%0d_done", i), 32'(done_s[i]), 32'(m_act[i] && m_off[i] == l));
            check_eq($sformatf("d%0d_mem_wr", i), 32'(mwr_s[i]),
                     32'(m_act[i] && m_ss[i] != 2'b00 && m_off[i] == l - 1));
            check_eq($sformatf("d%0d_mem_addr", i), maddr_s[i], e_addr[i]);
            check_eq($sformatf("d%0d_mem_wdata", i), wdata_s[i], e_wdata[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        @(negedge clk);
        check_all();
    endtask

    // One store with start pulsed mid-operation and operands scrambled after acceptance.
    task automatic do_op(input int i, input logic [1:0] ss, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rd);
        seed[i]    = rd ^ (a * K);
        start_s[i] = 1'b1;
        ss_s[i]    = ss;
        addr_s[i]  = a;
        b_s[i]     = b;
        step();
        for (int k = 0; k < 20 && busy_s[i]; k++) begin
            start_s[i] = (k == 1);
            ss_s[i]    = 2'($urandom);
            addr_s[i]  = $urandom;
            b_s[i]     = $urandom;
            step();
        end
        start_s[i] = 1'b0;
        check_eq($sformatf("d%0d_idle_after_op", i), 32'(busy_s[i]), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            ss_s[i]    = 2'b00;
            addr_s[i]  = 32'h0;
            b_s[i]     = 32'h0;
            seed[i]    = 32'h0;
            m_act[i]   = 1'b0;
            m_off[i]   = 0;
            m_ss[i]    = 2'b00;
        end
        #2 reset = 1'b0;
        #1 model_update(0);
        model_update(1);
        check_all();
        step();
        step();
        reset = 1'b1;
        step();

        do_op(0, 2'b01, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0);
        check_eq("sw_wdata", wdata_s[0], 32'hDEAD_BEEF);
        do_op(0, 2'b10, 32'h0000_0100, 32'h0000_00AA, 32'h1122_3344);
        check_eq("sb_wdata", wdata_s[0], 32'h1122_33AA);
        do_op(1, 2'b11, 32'h0000_0200, 32'h1234_BEEF, 32'hCAFE_0000);
        check_eq("sh_wdata", wdata_s[1], 32'hCAFE_BEEF);
        do_op(0, 2'b00, 32'h0000_0300, 32'h5555_5555, 32'h0);
        do_op(1, 2'b10, 32'h0000_0404, 32'h0000_0077, 32'hA5A5_A5A5);

        // Start held high across DONE starts a second store.
        start_s[0] = 1'b1;
        ss_s[0]    = 2'b01;
        addr_s[0]  = 32'h0000_0500;
        b_s[0]     = 32'h0BAD_F00D;
        repeat (4) step();
        start_s[0] = 1'b0;
        repeat (4) step();

        // Reset during WAIT of a byte store: no write may escape.
        seed[0]    = 32'h1357_9BDF;
        start_s[0] = 1'b1;
        ss_s[0]    = 2'b10;
        addr_s[0]  = 32'h0000_0600;
        b_s[0]     = 32'h0000_0011;
        step();
        start_s[0] = 1'b0;
        step();
        reset = 1'b0;
        #1 model_update(0);
        model_update(1);
        check_all();
        step();
        reset = 1'b1;
        step();
        do_op(0, 2'b01, 32'h0000_0700, 32'hFEED_FACE, 32'h0);
        check_eq("sw_after_reset", wdata_s[0], 32'hFEED_FACE);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                start_s[i] = ($urandom_range(0, 3) == 0);
                ss_s[i]    = 2'($urandom);
                addr_s[i]  = $urandom;
                b_s[i]     = $urandom;
            end
            step();
        end
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (10) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
